// File: rtl/keypad_code_entry.sv
// keypad_code_entry: assembles debounced keypad presses into a fixed-length
// BCD code word. Supports digit entry, backspace, clear, enter and an idle
// timeout, and hands the finished code to the lock with a one-cycle strobe.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | buffer empty, idle timer held at 0
// S_ENTRY | at least one digit buffered; idle timer counting between keys
module keypad_code_entry #(
   parameter int DIGITS         = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [3:0]            key_i,
   input  logic                  key_valid_i,
   output logic [DIGITS*4-1:0]   code_o,
   output logic                  code_valid_o,
   output logic [3:0]            digit_count_o,
   output logic                  entry_active_o,
   output logic                  err_o,
   output logic                  timeout_o
);

   localparam int BW = DIGITS * 4;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   // The timeout fires on the edge that would take the timer to TIMEOUT_CYCLES,
   // so the compare is against the value one below it.
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    CNT_FULL = 4'(DIGITS);

   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] KEY_ENTER = 4'hE;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ENTRY = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [BW-1:0]  buf_q, buf_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic [BW-1:0]  code_q, code_d;
   logic           code_valid_q, code_valid_d;
   logic           err_q, err_d;
   logic           timeout_q, timeout_d;

   // Next-state decode: at most one action per cycle, a sampled key always
   // takes priority over timer expiry.
   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      cnt_d        = cnt_q;
      tmr_d        = tmr_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      err_d        = 1'b0;
      timeout_d    = 1'b0;

      if (key_valid_i) begin
         tmr_d = '0;
         case (key_i)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
               if (cnt_q < CNT_FULL) begin
                  buf_d   = (buf_q << 4) | BW'(key_i);
                  cnt_d   = cnt_q + 4'd1;
                  state_d = S_ENTRY;
               end else begin
                  err_d = 1'b1;
               end
            end
            KEY_BKSP: begin
               if (cnt_q != 4'd0) begin
                  buf_d = buf_q >> 4;
                  cnt_d = cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     state_d = S_IDLE;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            KEY_CLEAR: begin
               buf_d   = '0;
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end
            KEY_ENTER: begin
               if (cnt_q == CNT_FULL) begin
                  code_d       = buf_q;
                  code_valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               buf_d   = '0;
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end
            default: begin
               err_d = 1'b1;
            end
         endcase
      end else if (state_q == S_ENTRY) begin
         if (tmr_q == TMR_LAST) begin
            buf_d     = '0;
            cnt_d     = 4'd0;
            tmr_d     = '0;
            timeout_d = 1'b1;
            state_d   = S_IDLE;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
   end

   // State, buffer, timer and all registered outputs.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         buf_q        <= '0;
         cnt_q        <= 4'd0;
         tmr_q        <= '0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         tmr_q        <= tmr_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         err_q        <= err_d;
         timeout_q    <= timeout_d;
      end
   end

   assign code_o         = code_q;
   assign code_valid_o   = code_valid_q;
   assign digit_count_o  = cnt_q;
   assign entry_active_o = (state_q == S_ENTRY);
   assign err_o          = err_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Bench for keypad_code_entry: table of directed keypresses with expected
// outputs, hand-written timeout and async-reset sequences, then random keys
// checked against a queue-based model of the keypad rules.
module tb_keypad_code_entry;

   localparam int DIG = 4;
   localparam int TO  = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  key;
   logic        kv;
   logic [15:0] code;
   logic        cv;
   logic [3:0]  cnt;
   logic        ent;
   logic        err;
   logic        tmo;

   keypad_code_entry #(.DIGITS(DIG), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .key_i          (key),
      .key_valid_i    (kv),
      .code_o         (code),
      .code_valid_o   (cv),
      .digit_count_o  (cnt),
      .entry_active_o (ent),
      .err_o          (err),
      .timeout_o      (tmo)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: buffered digits kept as a queue, idle cycles as a count.
   int          mq[$];
   int          m_idle;
   logic [15:0] m_code;
   bit          m_cv, m_err, m_to;

   typedef struct {
      bit          kv;
      logic [3:0]  key;
      logic [15:0] code;
      bit          cv;
      logic [3:0]  cnt;
      bit          err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_idle = 0;
      m_code = 16'h0;
      m_cv   = 0;
      m_err  = 0;
      m_to   = 0;
   endfunction

   function automatic void model_step(input bit v, input logic [3:0] k);
      m_cv  = 0;
      m_err = 0;
      m_to  = 0;
      if (v) begin
         m_idle = 0;
         if (k <= 4'd9) begin
            if (mq.size() < DIG) mq.push_back(int'(k));
            else m_err = 1;
         end else if (k == 4'hB) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else m_err = 1;
         end else if (k == 4'hC) begin
            mq.delete();
         end else if (k == 4'hE) begin
            if (mq.size() == DIG) begin
               m_code = 16'h0;
               foreach (mq[i]) m_code = {m_code[11:0], 4'(mq[i])};
               m_cv = 1;
            end else begin
               m_err = 1;
            end
            mq.delete();
         end else begin
            m_err = 1;
         end
      end else if (mq.size() > 0) begin
         m_idle++;
         if (m_idle == TO) begin
            mq.delete();
            m_idle = 0;
            m_to   = 1;
         end
      end
   endfunction

   task automatic check_model();
      chk("mdl_code",  32'(code), 32'(m_code));
      chk("mdl_cv",    32'(cv),   32'(m_cv));
      chk("mdl_cnt",   32'(cnt),  32'(mq.size()));
      chk("mdl_entry", 32'(ent),  32'(mq.size() > 0));
      chk("mdl_err",   32'(err),  32'(m_err));
      chk("mdl_tmo",   32'(tmo),  32'(m_to));
   endtask

   // One clock: drive inputs, let the edge happen, then compare #1 later.
   task automatic step(input bit v, input logic [3:0] k);
      kv  = v;
      key = k;
      @(posedge clk);
      model_step(v, k);
      #1;
      check_model();
   endtask

   task automatic add(input bit v, input logic [3:0] k, input logic [15:0] c,
                      input bit vc, input logic [3:0] n, input bit e);
      vec_t t;
      t.kv = v; t.key = k; t.code = c; t.cv = vc; t.cnt = n; t.err = e;
      tbl.push_back(t);
   endtask

   initial begin
      reset = 1'b1;
      kv    = 1'b0;
      key   = 4'h0;
      model_reset();

      // basic entry and submit
      add(1, 4'h1, 16'h0000, 0, 1, 0);
      add(1, 4'h0, 16'h0000, 0, 2, 0);
      add(1, 4'h1, 16'h0000, 0, 3, 0);
      add(1, 4'h0, 16'h0000, 0, 4, 0);
      add(1, 4'hE, 16'h1010, 1, 0, 0);
      // overflow refused, then submit (key directly after code_valid)
      add(1, 4'h1, 16'h1010, 0, 1, 0);
      add(1, 4'h2, 16'h1010, 0, 2, 0);
      add(1, 4'h3, 16'h1010, 0, 3, 0);
      add(1, 4'h4, 16'h1010, 0, 4, 0);
      add(1, 4'h5, 16'h1010, 0, 4, 1);
      add(1, 4'hE, 16'h1234, 1, 0, 0);
      // backspace leaves 0x79, made visible by padding and submitting
      add(1, 4'h7, 16'h1234, 0, 1, 0);
      add(1, 4'h8, 16'h1234, 0, 2, 0);
      add(1, 4'hB, 16'h1234, 0, 1, 0);
      add(1, 4'h9, 16'h1234, 0, 2, 0);
      add(1, 4'h0, 16'h1234, 0, 3, 0);
      add(1, 4'h0, 16'h1234, 0, 4, 0);
      add(1, 4'hE, 16'h7900, 1, 0, 0);
      // same with clear, then a fresh code
      add(1, 4'h7, 16'h7900, 0, 1, 0);
      add(1, 4'h8, 16'h7900, 0, 2, 0);
      add(1, 4'hB, 16'h7900, 0, 1, 0);
      add(1, 4'h9, 16'h7900, 0, 2, 0);
      add(1, 4'hC, 16'h7900, 0, 0, 0);
      add(1, 4'h1, 16'h7900, 0, 1, 0);
      add(1, 4'h2, 16'h7900, 0, 2, 0);
      add(1, 4'h3, 16'h7900, 0, 3, 0);
      add(1, 4'h4, 16'h7900, 0, 4, 0);
      add(1, 4'hE, 16'h1234, 1, 0, 0);
      // short enter, and rejected keys on an empty buffer
      add(1, 4'h1, 16'h1234, 0, 1, 0);
      add(1, 4'h2, 16'h1234, 0, 2, 0);
      add(1, 4'hE, 16'h1234, 0, 0, 1);
      add(1, 4'hB, 16'h1234, 0, 0, 1);
      add(1, 4'hF, 16'h1234, 0, 0, 1);
      add(1, 4'hC, 16'h1234, 0, 0, 0);
      add(1, 4'hA, 16'h1234, 0, 0, 1);
      add(1, 4'hD, 16'h1234, 0, 0, 1);
      add(0, 4'hE, 16'h1234, 0, 0, 0);

      #12;
      chk("rst_code",  32'(code), 32'h0);
      chk("rst_cv",    32'(cv),   32'h0);
      chk("rst_cnt",   32'(cnt),  32'h0);
      chk("rst_entry", 32'(ent),  32'h0);
      chk("rst_err",   32'(err),  32'h0);
      chk("rst_tmo",   32'(tmo),  32'h0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].kv, tbl[i].key);
         chk($sformatf("tbl%0d_code", i),  32'(code), 32'(tbl[i].code));
         chk($sformatf("tbl%0d_cv", i),    32'(cv),   32'(tbl[i].cv));
         chk($sformatf("tbl%0d_cnt", i),   32'(cnt),  32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_err", i),   32'(err),  32'(tbl[i].err));
         chk($sformatf("tbl%0d_entry", i), 32'(ent),  32'(tbl[i].cnt != 4'd0));
         chk($sformatf("tbl%0d_tmo", i),   32'(tmo),  32'h0);
      end

      // timeout lands exactly TO edges after the last key
      step(1, 4'h3);
      chk("to_entry_on", 32'(ent), 32'h1);
      for (int i = 1; i < TO; i++) begin
         step(0, 4'h0);
         chk($sformatf("to_early%0d", i), 32'(tmo), 32'h0);
      end
      step(0, 4'h0);
      chk("to_fire",  32'(tmo), 32'h1);
      chk("to_cnt",   32'(cnt), 32'h0);
      chk("to_entry", 32'(ent), 32'h0);
      step(0, 4'h0);
      chk("to_one_cycle", 32'(tmo), 32'h0);

      // key on the expiry cycle wins over the timer
      step(1, 4'h3);
      for (int i = 1; i < TO; i++) step(0, 4'h0);
      step(1, 4'h4);
      chk("to_race_tmo", 32'(tmo), 32'h0);
      chk("to_race_cnt", 32'(cnt), 32'h2);
      for (int i = 1; i < TO; i++) step(0, 4'h0);
      chk("to_reload_tmo", 32'(tmo), 32'h0);
      step(0, 4'h0);
      chk("to_reload_fire", 32'(tmo), 32'h1);

      // async reset mid-cycle with three digits buffered
      step(1, 4'h1);
      step(1, 4'h2);
      step(1, 4'h3);
      chk("ar_cnt_before", 32'(cnt), 32'h3);
      #3;
      reset = 1'b1;
      #1;
      chk("ar_code",  32'(code), 32'h0);
      chk("ar_cnt",   32'(cnt),  32'h0);
      chk("ar_entry", 32'(ent),  32'h0);
      chk("ar_cv",    32'(cv),   32'h0);
      chk("ar_err",   32'(err),  32'h0);
      chk("ar_tmo",   32'(tmo),  32'h0);
      #2;
      reset = 1'b0;
      model_reset();
      step(1, 4'h5);
      step(1, 4'h6);
      step(1, 4'h7);
      step(1, 4'h8);
      step(1, 4'hE);
      chk("ar_code_after", 32'(code), 32'h5678);
      chk("ar_cv_after",   32'(cv),   32'h1);

      // random keys, alternating busy and sparse phases to reach timeouts
      for (int i = 0; i < 600; i++) begin
         bit          v;
         logic [3:0]  k;
         int          pct;
         pct = ((i / 50) % 2 == 0) ? 60 : 12;
         v   = ($urandom_range(0, 99) < pct);
         k   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) k = 4'($urandom_range(0, 9));
         step(v, k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
